// File: rtl/trace_buffer_trig_pkg.sv
// ---------------------------------------------------------------------------
// trace_buffer_pkg
// Shared types and constants for the triggered trace buffer:
//   tb_state_e  capture FSM states (IDLE/RUN/POST/DONE, encoded 0..3)
//   tb_mode_e   run mode (CIRCULAR = free-running, TRIG_STOP = stop after
//               a programmable number of post-trigger entries)
//   RD_LATENCY  cycles from rd_req to rd_valid
//   TS_WIDTH    width of the optional capture timestamp
// ---------------------------------------------------------------------------
package trace_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } tb_state_e;

  typedef enum logic {
    CIRCULAR  = 1'b0,
    TRIG_STOP = 1'b1
  } tb_mode_e;

  localparam int RD_LATENCY = 2;
  localparam int TS_WIDTH   = 32;

endpackage

// File: rtl/trace_buffer_trig_if.sv
// ---------------------------------------------------------------------------
// trace_buffer_trig_if
// Capture and read-out bus of the trace buffer.
//   Capture side : tracing, valid_in, compression_flag_in, inc_tb_ptr,
//                  vector_in (N lanes x DATA_WIDTH)
//   Read side    : rd_req, rd_offset  ->  vector_out, compression_flag_out,
//                  rd_valid (and timestamp_out when TRACE_BUFFER_TIMESTAMP_EN
//                  is defined)
//   Status       : wrapped (write pointer has lapped a full buffer)
// master = the producer/host side, slave = the trace buffer.
// ---------------------------------------------------------------------------
interface trace_buffer_trig_if
  import trace_buffer_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TB_SIZE    = 64
);
  localparam int AW = $clog2(TB_SIZE);

  logic                          tracing;
  logic                          valid_in;
  logic                          compression_flag_in;
  logic                          inc_tb_ptr;
  logic [N-1:0][DATA_WIDTH-1:0]  vector_in;

  logic                          rd_req;
  logic [AW-1:0]                 rd_offset;
  logic [N-1:0][DATA_WIDTH-1:0]  vector_out;
  logic                          compression_flag_out;
  logic                          rd_valid;
  logic                          wrapped;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]           timestamp_out;
`endif

  modport master (
    output tracing, valid_in, compression_flag_in, inc_tb_ptr, vector_in,
    output rd_req, rd_offset,
    input  vector_out, compression_flag_out, rd_valid, wrapped
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    , input timestamp_out
`endif
  );

  modport slave (
    input  tracing, valid_in, compression_flag_in, inc_tb_ptr, vector_in,
    input  rd_req, rd_offset,
    output vector_out, compression_flag_out, rd_valid, wrapped
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    , output timestamp_out
`endif
  );

endinterface

// File: rtl/ram_dual_port.sv
// ---------------------------------------------------------------------------
// ram_dual_port
// Simple dual-port RAM, one write port and one registered read port
// (read latency 1). A read and write to the same address in the same cycle
// returns the old contents. Contents are not reset.
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr       read port (rdata updates only when re=1)
//   rdata          registered read data
// ---------------------------------------------------------------------------
module ram_dual_port #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_buffer_trig_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_capture_ctrl
// Capture FSM and write-side bookkeeping of the trace buffer.
//   clk, reset     clock, synchronous active-high reset
//   arm            pulse: clear buffer state and enter RUN
//   mode           0 = circular, 1 = trigger-stop
//   trigger        trigger event (acted on only in RUN)
//   post_trig      entries to capture after the trigger, sampled on trigger
//   wr_req         valid_in & tracing from the capture bus
//   inc_tb_ptr     1 = new slot, 0 = merge into current slot
//   wr_en/wr_addr  RAM write strobe and address
//   wr_ptr         slot holding the newest entry
//   occupancy      valid entries (saturates at TB_SIZE)
//   wrapped        pointer has lapped a full buffer
//   triggered      trigger seen since arm
//   state          FSM state
// ---------------------------------------------------------------------------
module tb_capture_ctrl
  import trace_buffer_pkg::*;
#(
  parameter  int TB_SIZE = 64,
  localparam int AW      = $clog2(TB_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          mode,
  input  logic          trigger,
  input  logic [AW:0]   post_trig,
  input  logic          wr_req,
  input  logic          inc_tb_ptr,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] wr_ptr,
  output logic [AW:0]   occupancy,
  output logic          wrapped,
  output logic          triggered,
  output tb_state_e     state
);

  localparam logic [AW:0]   OCC_FULL = (AW+1)'(TB_SIZE);
  localparam logic [AW-1:0] PTR_LAST = AW'(TB_SIZE - 1);

  tb_state_e     state_reg, state_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW:0]   occ_reg, occ_next;
  logic          wrapped_reg, wrapped_next;
  logic          trig_reg, trig_next;
  logic [AW:0]   post_cnt_reg, post_cnt_next;
  logic [AW:0]   post_trig_reg, post_trig_next;

  logic          capturing;
  logic          new_slot;
  logic [AW+1:0] post_sum;

  always_comb begin
    capturing      = (state_reg == RUN) || (state_reg == POST);
    // arm wins over a coincident write: the buffer is being cleared
    wr_en          = wr_req & capturing & ~arm;
    // a merge into an empty buffer has nothing to merge with, so it
    // takes a fresh slot instead
    new_slot       = inc_tb_ptr | (occ_reg == '0);
    wr_addr        = new_slot ? AW'(wr_ptr_reg + 1'b1) : wr_ptr_reg;

    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    occ_next       = occ_reg;
    wrapped_next   = wrapped_reg;
    trig_next      = trig_reg;
    post_cnt_next  = post_cnt_reg;
    post_trig_next = post_trig_reg;
    post_sum       = {1'b0, post_cnt_reg} + {{(AW+1){1'b0}}, (wr_en & new_slot)};

    if (wr_en && new_slot) begin
      wr_ptr_next = wr_addr;
      if (occ_reg != OCC_FULL) occ_next = occ_reg + 1'b1;
      if ((wr_ptr_reg == PTR_LAST) && (occ_reg == OCC_FULL)) wrapped_next = 1'b1;
    end

    case (state_reg)
      RUN: begin
        if (trigger) begin
          trig_next = 1'b1;
          if (mode == TRIG_STOP) begin
            post_trig_next = post_trig;
            post_cnt_next  = '0;
            // the write in the trigger cycle is pre-trigger; with no
            // post-trigger depth the capture freezes right away
            state_next     = (post_trig == '0) ? DONE : POST;
          end
        end
      end
      POST: begin
        post_cnt_next = post_sum[AW:0];
        if (post_sum >= {1'b0, post_trig_reg}) state_next = DONE;
      end
      default: ;
    endcase

    if (arm) begin
      state_next    = RUN;
      wr_ptr_next   = PTR_LAST;
      occ_next      = '0;
      wrapped_next  = 1'b0;
      trig_next     = 1'b0;
      post_cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= PTR_LAST;
      occ_reg       <= '0;
      wrapped_reg   <= 1'b0;
      trig_reg      <= 1'b0;
      post_cnt_reg  <= '0;
      post_trig_reg <= '0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      occ_reg       <= occ_next;
      wrapped_reg   <= wrapped_next;
      trig_reg      <= trig_next;
      post_cnt_reg  <= post_cnt_next;
      post_trig_reg <= post_trig_next;
    end
  end

  assign wr_ptr    = wr_ptr_reg;
  assign occupancy = occ_reg;
  assign wrapped   = wrapped_reg;
  assign triggered = trig_reg;
  assign state     = state_reg;

endmodule

// File: rtl/trace_buffer_trig.sv
// ---------------------------------------------------------------------------
// trace_buffer_trig
// Triggered circular trace buffer for N-lane vectors plus a compression flag.
// Capture runs free (circular) or stops a programmable number of entries
// after a trigger. Read-out is chronological: rd_offset 0 is the oldest
// entry; data appears two cycles after rd_req together with rd_valid.
//   clk, reset    clock, synchronous active-high reset
//   bus           trace_buffer_trig_if.slave (capture + read-out + wrapped)
//   mode          0 = circular, 1 = trigger-stop
//   arm           pulse: clear buffer state and start capture
//   trigger       trigger event
//   post_trig     entries to capture after the trigger (0..TB_SIZE)
//   occupancy     valid entries
//   triggered     trigger seen since arm
//   done          capture frozen
//   state         FSM state
// Optional: TRACE_BUFFER_TIMESTAMP_EN adds a free-running cycle counter
// stored with each entry and returned on bus.timestamp_out.
// ---------------------------------------------------------------------------
module trace_buffer_trig
  import trace_buffer_pkg::*;
#(
  parameter  int N          = 8,
  parameter  int DATA_WIDTH = 32,
  parameter  int TB_SIZE    = 64,
  localparam int AW         = $clog2(TB_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  trace_buffer_trig_if.slave   bus,
  input  logic                 mode,
  input  logic                 arm,
  input  logic                 trigger,
  input  logic [AW:0]          post_trig,
  output logic [AW:0]          occupancy,
  output logic                 triggered,
  output logic                 done,
  output logic [1:0]           state
);

  localparam logic [AW:0] OCC_FULL = (AW+1)'(TB_SIZE);

  tb_state_e       ctrl_state;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   wr_ptr;
  logic            wrapped;
  logic [AW-1:0]   oldest;
  logic [AW-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0] ram_q [N];
  logic            flag_q;
  logic [RD_LATENCY-1:0] rd_pipe_reg;

  tb_capture_ctrl #(.TB_SIZE(TB_SIZE)) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .mode       (mode),
    .trigger    (trigger),
    .post_trig  (post_trig),
    .wr_req     (bus.valid_in & bus.tracing),
    .inc_tb_ptr (bus.inc_tb_ptr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_ptr     (wr_ptr),
    .occupancy  (occupancy),
    .wrapped    (wrapped),
    .triggered  (triggered),
    .state      (ctrl_state)
  );

  assign state       = ctrl_state;
  assign done        = (ctrl_state == DONE);
  assign bus.wrapped = wrapped;

  // Until the buffer fills, slot 0 is the oldest; once full, the slot after
  // the newest entry is the next to be overwritten and therefore the oldest.
  always_comb begin
    oldest  = (occupancy == OCC_FULL) ? AW'(wr_ptr + 1'b1) : '0;
    rd_addr = AW'(oldest + bus.rd_offset);
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    ram_dual_port #(.WIDTH(DATA_WIDTH), .DEPTH(TB_SIZE)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (bus.vector_in[gi]),
      .re    (bus.rd_req),
      .raddr (rd_addr),
      .rdata (ram_q[gi])
    );
  end

  ram_dual_port #(.WIDTH(1), .DEPTH(TB_SIZE)) u_flag_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (bus.compression_flag_in),
    .re    (bus.rd_req),
    .raddr (rd_addr),
    .rdata (flag_q)
  );

`ifdef TRACE_BUFFER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt_reg;
  logic [TS_WIDTH-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (reset) ts_cnt_reg <= '0;
    else       ts_cnt_reg <= ts_cnt_reg + 1'b1;
  end

  // a merge rewrites the slot, so it naturally refreshes the timestamp
  ram_dual_port #(.WIDTH(TS_WIDTH), .DEPTH(TB_SIZE)) u_ts_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (ts_cnt_reg),
    .re    (bus.rd_req),
    .raddr (rd_addr),
    .rdata (ts_q)
  );
`endif

  // Stage 0 of the pipe tracks the RAM read; the output register loads when
  // that stage is set, so rd_valid and the data leave together.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pipe_reg              <= '0;
      bus.vector_out           <= '0;
      bus.compression_flag_out <= 1'b0;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
      bus.timestamp_out        <= '0;
`endif
    end else begin
      rd_pipe_reg <= {rd_pipe_reg[RD_LATENCY-2:0], bus.rd_req};
      if (rd_pipe_reg[0]) begin
        for (int i = 0; i < N; i++) bus.vector_out[i] <= ram_q[i];
        bus.compression_flag_out <= flag_q;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
        bus.timestamp_out        <= ts_q;
`endif
      end
    end
  end

  assign bus.rd_valid = rd_pipe_reg[RD_LATENCY-1];

endmodule

// File: tb/tb_trace_buffer_trig.sv
// ---------------------------------------------------------------------------
// tb_trace_buffer_trig
// Randomized bench for trace_buffer_trig (TB_SIZE=8, N=2). The reference
// model keeps the buffer as a chronological queue of entries (oldest first)
// plus a small capture-mode state; read-out is compared against it.
// ---------------------------------------------------------------------------
module tb_trace_buffer_trig;
  import trace_buffer_pkg::*;

  localparam int N   = 2;
  localparam int DW  = 16;
  localparam int TBS = 8;
  localparam int AW  = 3;

  typedef logic [N-1:0][DW-1:0] vec_t;
  typedef struct {
    vec_t data;
    logic flag;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          mode;
  logic          arm;
  logic          trigger;
  logic [AW:0]   post_trig;
  logic [AW:0]   occupancy;
  logic          triggered;
  logic          done;
  logic [1:0]    state;

  trace_buffer_trig_if #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS)) bus ();

  trace_buffer_trig #(.N(N), .DATA_WIDTH(DW), .TB_SIZE(TBS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mode      (mode),
    .arm       (arm),
    .trigger   (trigger),
    .post_trig (post_trig),
    .occupancy (occupancy),
    .triggered (triggered),
    .done      (done),
    .state     (state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model
  entry_t mq[$];
  int     m_state;      // 0 idle, 1 run, 2 post, 3 done
  int     m_post_left;
  bit     m_trig;
  int     m_pushes;

  // read-burst capture
  logic got_vld [TBS+3];
  vec_t got_dat [TBS+3];
  logic got_flg [TBS+3];
`ifdef TRACE_BUFFER_TIMESTAMP_EN
  logic [31:0] got_ts [TBS+3];
`endif

  function automatic vec_t rand_vec();
    vec_t v;
    for (int l = 0; l < N; l++) v[l] = DW'($urandom());
    return v;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_state = 0; m_post_left = 0; m_trig = 0; m_pushes = 0;
  endfunction

  function automatic void model_arm();
    mq.delete();
    m_state = 1; m_post_left = 0; m_trig = 0; m_pushes = 0;
  endfunction

  function automatic void model_step(bit v, bit tr, bit inc, bit fl, vec_t vec, bit trig);
    int st0;
    bit ns;
    entry_t e;
    st0 = m_state;
    e.data = vec;
    e.flag = fl;
    if (v && tr && (st0 == 1 || st0 == 2)) begin
      ns = inc || (mq.size() == 0);
      if (ns) begin
        mq.push_back(e);
        m_pushes++;
        if (mq.size() > TBS) void'(mq.pop_front());
      end else begin
        mq[mq.size()-1] = e;
      end
      if (st0 == 2 && ns) begin
        m_post_left--;
        if (m_post_left <= 0) m_state = 3;
      end
    end
    if (trig && st0 == 1) begin
      m_trig = 1;
      if (mode) begin
        m_post_left = int'(post_trig);
        m_state = (post_trig == 0) ? 3 : 2;
      end
    end
  endfunction

  task automatic drive_cycle(input bit v, input bit tr, input bit inc, input bit fl,
                             input vec_t vec, input bit trig);
    bus.valid_in = v; bus.tracing = tr; bus.inc_tb_ptr = inc;
    bus.compression_flag_in = fl; bus.vector_in = vec; trigger = trig;
    @(posedge clk); #1;
    bus.valid_in = 1'b0; trigger = 1'b0;
    model_step(v, tr, inc, fl, vec, trig);
  endtask

  task automatic do_reset();
    reset = 1'b1; arm = 1'b0; trigger = 1'b0;
    bus.valid_in = 1'b0; bus.tracing = 1'b0; bus.rd_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    model_arm();
  endtask

  // Back-to-back reads at offsets 0..cnt-1; records the outputs seen at each
  // cycle, so index k holds the response to request k-2.
  task automatic read_burst(input int cnt);
    for (int j = 0; j < cnt + 3; j++) begin
      got_vld[j] = bus.rd_valid;
      got_dat[j] = bus.vector_out;
      got_flg[j] = bus.compression_flag_out;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
      got_ts[j]  = bus.timestamp_out;
`endif
      bus.rd_req    = (j < cnt);
      bus.rd_offset = AW'(j);
      @(posedge clk); #1;
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (bus.rd_valid !== 1'b0 || bus.vector_out !== '0 || bus.compression_flag_out !== 1'b0)
      begin errors++; $display("FAIL reset_rd got vld=%b data=%h flag=%b exp 0/0/0", bus.rd_valid, bus.vector_out, bus.compression_flag_out); end
    checks++; if (triggered !== 1'b0 || done !== 1'b0 || bus.wrapped !== 1'b0)
      begin errors++; $display("FAIL reset_flags got trig=%b done=%b wrap=%b exp 0", triggered, done, bus.wrapped); end
    for (int i = 0; i < 4; i++) drive_cycle(1, 1, 1, 1, rand_vec(), 0);
    checks++; if (occupancy !== (AW+1)'(mq.size())) begin errors++; $display("FAIL idle_occ got=%0d exp=%0d", occupancy, mq.size()); end
    checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL idle_state got=%0d exp=%0d", state, m_state); end
    $display("test_reset done");
  endtask

  task automatic test_circular();
    mode = 1'b0; post_trig = '0;
    do_arm();
    for (int i = 0; i < 10; i++) drive_cycle(1, 1, 1, 1'($urandom_range(0, 1)), rand_vec(), i == 3);
    checks++; if (occupancy !== (AW+1)'(mq.size())) begin errors++; $display("FAIL circ_occ got=%0d exp=%0d", occupancy, mq.size()); end
    checks++; if (bus.wrapped !== 1'(m_pushes > TBS)) begin errors++; $display("FAIL circ_wrap got=%b exp=%b", bus.wrapped, m_pushes > TBS); end
    checks++; if (triggered !== 1'(m_trig) || state !== 2'(m_state))
      begin errors++; $display("FAIL circ_trig got trig=%b state=%0d exp trig=%b state=%0d", triggered, state, m_trig, m_state); end
    read_burst(mq.size());
    for (int k = 0; k < mq.size() + 3; k++) begin
      bit ev;
      ev = (k >= 2) && (k < mq.size() + 2);
      checks++; if (got_vld[k] !== ev) begin errors++; $display("FAIL circ_rd_valid[%0d] got=%b exp=%b", k, got_vld[k], ev); end
      if (ev) begin
        checks++;
        if (got_dat[k] !== mq[k-2].data || got_flg[k] !== mq[k-2].flag) begin
          errors++; $display("FAIL circ_rd off=%0d got=%h/%b exp=%h/%b", k-2, got_dat[k], got_flg[k], mq[k-2].data, mq[k-2].flag);
        end else $display("circ read off=%0d data=%h flag=%b", k-2, got_dat[k], got_flg[k]);
`ifdef TRACE_BUFFER_TIMESTAMP_EN
        if (k >= 3) begin
          checks++; if (!(got_ts[k] > got_ts[k-1])) begin errors++; $display("FAIL circ_ts off=%0d got=%0d prev=%0d", k-2, got_ts[k], got_ts[k-1]); end
        end
`endif
      end
    end
  endtask

  task automatic test_merge();
    vec_t a, b;
    mode = 1'b0;
    do_arm();
    a = rand_vec(); b = rand_vec();
    drive_cycle(1, 1, 1, 0, a, 0);
    drive_cycle(1, 1, 0, 1, b, 0);
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL merge_occ got=%0d exp=1", occupancy); end
    read_burst(1);
    checks++; if (got_vld[2] !== 1'b1 || got_dat[2] !== b || got_flg[2] !== 1'b1)
      begin errors++; $display("FAIL merge_rd got=%b/%h/%b exp=1/%h/1", got_vld[2], got_dat[2], got_flg[2], b); end
    else $display("merge read off=0 data=%h", got_dat[2]);
    // merge on an empty buffer takes slot 0
    do_arm();
    drive_cycle(1, 1, 0, 0, a, 0);
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL merge_empty_occ got=%0d exp=1", occupancy); end
    for (int i = 0; i < 14; i++)
      drive_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), rand_vec(), 0);
    checks++; if (occupancy !== (AW+1)'(mq.size())) begin errors++; $display("FAIL merge_rand_occ got=%0d exp=%0d", occupancy, mq.size()); end
    checks++; if (bus.wrapped !== 1'(m_pushes > TBS)) begin errors++; $display("FAIL merge_wrap got=%b exp=%b", bus.wrapped, m_pushes > TBS); end
    read_burst(mq.size());
    for (int k = 2; k < mq.size() + 2; k++) begin
      checks++;
      if (got_vld[k] !== 1'b1 || got_dat[k] !== mq[k-2].data || got_flg[k] !== mq[k-2].flag) begin
        errors++; $display("FAIL merge_rand_rd off=%0d got=%b/%h/%b exp=1/%h/%b", k-2, got_vld[k], got_dat[k], got_flg[k], mq[k-2].data, mq[k-2].flag);
      end else $display("merge read off=%0d data=%h flag=%b", k-2, got_dat[k], got_flg[k]);
    end
  endtask

  task automatic test_trigger_stop();
    int pts[3] = '{3, 8, 10};
    int n;
    for (int r = 0; r < 3; r++) begin
      mode = 1'b1; post_trig = (AW+1)'(pts[r]);
      do_arm();
      n = 0;
      while (n < 26) begin
        if ($urandom_range(0, 3) == 0) begin
          drive_cycle(1, 0, 1, 0, rand_vec(), 0);
        end else begin
          n++;
          drive_cycle(1, 1, 1, 1'($urandom_range(0, 1)), rand_vec(), n == 6);
          checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL stop_state pt=%0d wr=%0d got=%0d exp=%0d", pts[r], n, state, m_state); end
        end
      end
      checks++; if (occupancy !== (AW+1)'(mq.size()) || done !== 1'b1 || triggered !== 1'b1)
        begin errors++; $display("FAIL stop_final pt=%0d got occ=%0d done=%b trig=%b exp occ=%0d done=1 trig=1", pts[r], occupancy, done, triggered, mq.size()); end
      read_burst(mq.size());
      for (int k = 2; k < mq.size() + 2; k++) begin
        checks++;
        if (got_vld[k] !== 1'b1 || got_dat[k] !== mq[k-2].data || got_flg[k] !== mq[k-2].flag) begin
          errors++; $display("FAIL stop_rd pt=%0d off=%0d got=%b/%h/%b exp=1/%h/%b", pts[r], k-2, got_vld[k], got_dat[k], got_flg[k], mq[k-2].data, mq[k-2].flag);
        end else $display("stop read pt=%0d off=%0d data=%h", pts[r], k-2, got_dat[k]);
      end
    end
  endtask

  task automatic test_post_zero();
    mode = 1'b1; post_trig = '0;
    do_arm();
    drive_cycle(0, 1, 1, 0, rand_vec(), 1);
    checks++; if (state !== 2'd3 || done !== 1'b1 || triggered !== 1'b1)
      begin errors++; $display("FAIL post0_done got state=%0d done=%b trig=%b exp 3/1/1", state, done, triggered); end
    drive_cycle(1, 1, 1, 0, rand_vec(), 0);
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL post0_blocked got occ=%0d exp=0", occupancy); end
    do_arm();
    checks++; if (state !== 2'd1 || occupancy !== '0 || done !== 1'b0 || triggered !== 1'b0)
      begin errors++; $display("FAIL post0_rearm got state=%0d occ=%0d done=%b trig=%b exp 1/0/0/0", state, occupancy, done, triggered); end
    $display("test_post_zero done");
  endtask

  task automatic test_reset_mid_read();
    mode = 1'b0;
    do_arm();
    for (int i = 0; i < 5; i++) drive_cycle(1, 1, 1, 1'($urandom_range(0, 1)), rand_vec(), 0);
    bus.rd_req = 1'b1; bus.rd_offset = 3'd0;
    @(posedge clk); #1;
    bus.rd_offset = 3'd1;
    @(posedge clk); #1;
    checks++; if (bus.rd_valid !== 1'b1 || bus.vector_out !== mq[0].data)
      begin errors++; $display("FAIL midrd_first got=%b/%h exp=1/%h", bus.rd_valid, bus.vector_out, mq[0].data); end
    bus.rd_offset = 3'd2; reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.rd_valid !== 1'b0 || bus.vector_out !== '0)
      begin errors++; $display("FAIL midrd_cleared got=%b/%h exp=0/0", bus.rd_valid, bus.vector_out); end
    checks++; if (state !== 2'd0 || occupancy !== '0 || bus.wrapped !== 1'b0 || triggered !== 1'b0)
      begin errors++; $display("FAIL midrd_state got state=%0d occ=%0d exp 0/0", state, occupancy); end
    reset = 1'b0; bus.rd_req = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL midrd_pipe got=%b exp=0", bus.rd_valid); end
    $display("test_reset_mid_read done");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mode = 1'b0; arm = 1'b0; trigger = 1'b0; post_trig = '0;
    bus.tracing = 1'b0; bus.valid_in = 1'b0; bus.compression_flag_in = 1'b0;
    bus.inc_tb_ptr = 1'b0; bus.vector_in = '0; bus.rd_req = 1'b0; bus.rd_offset = '0;
    test_reset();
    test_circular();
    test_merge();
    test_trigger_stop();
    test_post_zero();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_buffer_trig.md
Name: trace_buffer_trig

Overview:
Parametrised successor to the circular trace buffer. It stores N-lane vectors plus a compression flag in dual-port RAM. It adds:
- synchronous reset and run modes (free-running circular, or trigger-stop with a programmable post-trigger depth);
- occupancy and wrap tracking;
- chronological read-out with a valid handshake.

It sits at the end of the debug datapath, after the filter and compression stages, and is read by the dump/host interface.

Parameters:
N, 8, vector lanes
DATA_WIDTH, 32, bits per lane
TB_SIZE, 64, entries; power of two, at least 4
AW, $clog2(TB_SIZE), address/count width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
tracing  in  1  capture enable
valid_in  in  1  input vector valid
compression_flag_in  in  1  flag stored with the entry
inc_tb_ptr  in  1  1 = new slot; 0 = overwrite current slot (compressed merge)
vector_in  in  N x DATA_WIDTH  input vector
mode  in  1  0 = circular, 1 = trigger-stop
arm  in  1  pulse; clears buffer state and starts capture
trigger  in  1  trigger event
post_trig  in  AW+1  entries to capture after trigger (0..TB_SIZE)
rd_req  in  1  read request
rd_offset  in  AW  offset from oldest entry (0 = oldest)
vector_out  out  N x DATA_WIDTH  read data
compression_flag_out  out  1  read flag
rd_valid  out  1  read data valid
occupancy  out  AW+1  valid entries (0..TB_SIZE)
triggered  out  1  trigger seen since arm
done  out  1  capture frozen
state  out  2  FSM state

Behaviour:
- Reset: FSM=IDLE, wr_ptr=TB_SIZE-1, occupancy=0, wrapped=0, triggered=0, done=0, rd_valid=0, vector_out=0, flag_out=0. RAM contents are not cleared.
- FSM states: IDLE(0), RUN(1), POST(2), DONE(3).
  - IDLE -> RUN on arm.
  - RUN -> POST when mode=1 and trigger.
  - POST -> DONE when post_cnt reaches post_trig.
  - arm from any state returns to RUN, clearing occupancy, wrapped, triggered, done and wr_ptr.
  - reset overrides arm.
  - trigger in IDLE/POST/DONE or with mode=0 is ignored; in mode=0 it only sets triggered.
- Write condition: wr_en = valid_in & tracing & state in {RUN,POST}.
  - Write address: inc_tb_ptr ? wr_ptr+1 : wr_ptr, modulo TB_SIZE.
  - On wr_en & inc_tb_ptr: wr_ptr advances; occupancy increments, saturating at TB_SIZE.
  - wrapped sets when wr_ptr goes from TB_SIZE-1 to 0 with occupancy already TB_SIZE.
- Merge writes: wr_en with inc_tb_ptr=0 and occupancy=0 is treated as inc_tb_ptr=1, so a merge never targets an empty buffer.
- Post-trigger counting:
  - In POST, post_cnt counts new-slot writes only.
  - post_trig is sampled on the trigger cycle.
  - post_trig=0 goes straight to DONE on the cycle after the trigger.
  - A trigger coincident with a write counts that write as pre-trigger.
  - post_trig at least TB_SIZE means the final buffer is entirely post-trigger.
- DONE: writes are blocked; done=1; read-out is still allowed.
- Read-out:
  - Physical address = (oldest + rd_offset) mod TB_SIZE, where oldest = 0 if occupancy<TB_SIZE, else wr_ptr+1.
  - Latency is 2 cycles: RAM read (1) plus output register (1). rd_valid is rd_req delayed by 2.
  - Back-to-back reads give one result per cycle.
  - Offsets at or beyond occupancy return stale RAM data with rd_valid=1; the host must bound them.
  - Same-cycle write and read to the same address returns old data.
- Reset mid-read: the rd_valid pipeline is cleared.

Optional Feature:
TRACE_BUFFER_TIMESTAMP_EN
- Defined:
  - A free-running 32-bit cycle counter (reset to 0) is written into a third RAM alongside each entry.
  - A merge write refreshes the stored timestamp.
  - Adds output timestamp_out (32 bits), aligned with rd_valid.
- Undefined: no counter, no RAM, no port.

Decomposition:
- Package trace_buffer_pkg:
  - tb_state_e enum (IDLE/RUN/POST/DONE);
  - tb_mode_e enum (CIRCULAR/TRIG_STOP);
  - RD_LATENCY=2 and TS_WIDTH=32.
- Storage reuses the existing ram_dual_port (latency 1): vector RAM, flag RAM, and the optional timestamp RAM.
- One new sub-module, tb_capture_ctrl, holds the FSM, wr_ptr, occupancy, wrapped and post_cnt, and outputs wr_addr and wr_en.
- The top level does address translation and the read pipeline.

Test Plan:
Unless stated, TB_SIZE=8 and N=2.
- Reset then idle: valid_in pulses with no arm -> occupancy=0, state=0, no RAM write.
- arm, mode=0, write 10 entries 1..10 with inc=1 -> occupancy=8, wrapped=1; reads offset 0..7 return 3..10, rd_valid two cycles after each rd_req.
- Merge: write 5 (inc=1), then 6 (inc=0) -> occupancy=1; offset 0 returns 6; first write with inc=0 after arm lands in slot 0, occupancy=1.
- mode=1, post_trig=3, write 1..20 with trigger during value 6 -> done after value 9; occupancy=8, buffer reads 2..9; later writes are ignored.
- post_trig=0: trigger with no write -> DONE next cycle; arm in DONE -> RUN with occupancy=0.
- reset asserted during 3 back-to-back reads -> rd_valid=0 the next cycle and all counters cleared; with TRACE_BUFFER_TIMESTAMP_EN defined, timestamps read back strictly increasing.
